// File: rtl/contador_control.sv
// contador_control: button-driven start/pause/clear sequencer stepping a bounded up/down counter on prescaler ticks
module contador_control #(
    parameter logic [27:0] DIVISOR   = 28'd50000000,
    parameter int          WIDTH     = 4,
    parameter int          MAX_COUNT = 9,
    parameter bit          WRAP      = 1'b1
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             btn_start,
    input  logic             btn_stop,
    input  logic             btn_dir,
    output logic [WIDTH-1:0] count_out,
    output logic             dir_out,
    output logic             running,
    output logic             tick,
    output logic             bound_pulse
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_COUNT);
    localparam logic [27:0]      LAST  = DIVISOR - 28'd1;
    state_t           state_q, state_d;
    logic [2:0]       sync1_q, sync1_d, sync2_q, sync2_d, edge_q, edge_d, pulse_q, pulse_d;
    logic [27:0]      presc_q, presc_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tick_q, tick_d, bound_q, bound_d, dir_q, dir_d;
    logic             start_p, stop_p, dir_p, at_bound;

    assign {dir_p, stop_p, start_p} = pulse_q;
    assign count_out   = count_q;
    assign dir_out     = dir_q;
    assign running     = state_q == RUN;
    assign tick        = tick_q;
    assign bound_pulse = bound_q;

    // Two-flop synchronizers followed by a registered rising-edge pulse per button ({dir, stop, start})
    always_comb begin
        sync1_d = {btn_dir, btn_stop, btn_start};
        sync2_d = sync1_q;
        edge_d  = sync2_q;
        pulse_d = sync2_q & ~edge_q;
    end

    // Stop outranks start: it pauses a running counter and clears a paused one back to idle
    always_comb begin
        state_d = state_q;
        if (stop_p) state_d = (state_q == RUN) ? PAUSE : IDLE;
        else if (start_p) state_d = RUN;
    end

    // Prescaler advances only while running, freezes in pause so resume keeps the partial period
    always_comb begin
        presc_d = '0;
        tick_d  = 1'b0;
        if (state_q == RUN) begin
            presc_d = (presc_q == LAST) ? '0 : presc_q + 28'd1;
            tick_d  = presc_q == LAST;
        end else if (state_q == PAUSE) begin
            presc_d = stop_p ? '0 : presc_q;
        end
    end

    // Counter steps on the registered tick using the direction held before any coincident toggle
    always_comb begin
        at_bound = dir_q ? (count_q == '0) : (count_q == MAX_W);
        count_d  = count_q;
        bound_d  = 1'b0;
        dir_d    = dir_q ^ dir_p;
        if (tick_q) begin
            bound_d = at_bound;
            count_d = dir_q ? (at_bound ? (WRAP ? MAX_W : count_q) : count_q - WIDTH'(1))
                            : (at_bound ? (WRAP ? '0 : count_q) : count_q + WIDTH'(1));
        end
        if (state_q == PAUSE && stop_p) count_d = '0;
    end

    // All state clears immediately on reset, independent of the clock
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sync1_q <= '0;
            sync2_q <= '0;
            edge_q  <= '0;
            pulse_q <= '0;
            presc_q <= '0;
            count_q <= '0;
            tick_q  <= 1'b0;
            bound_q <= 1'b0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            edge_q  <= edge_d;
            pulse_q <= pulse_d;
            presc_q <= presc_d;
            count_q <= count_d;
            tick_q  <= tick_d;
            bound_q <= bound_d;
            dir_q   <= dir_d;
        end
    end
endmodule
